wb_commit_stage: RTL

- Final pipeline stage. Drives the register file's write port (we/waddr/wdata) and the mem-stage forwarding bundle (mem_forwarding_we/waddr/wdata).
- Accepts one retiring instruction per cycle from MEM.
- For loads, waits for the dcache read response, then aligns and extends the returned word before commit.
- Back-pressures MEM with stall_req while a load response is outstanding.

---
 rtl/wb_commit_stage_pkg.sv | 22 ++
 rtl/wb_commit_stage_if.sv | 41 ++++
 rtl/wb_commit_stage_load_align.sv | 29 ++
 rtl/wb_commit_stage.sv | 98 +++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared encodings for the write-back/commit stage: load-op codes, FSM states
// and common constants.
package wb_commit_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LBU = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LHU = 3'd3;
  localparam logic [2:0] LOAD_LW  = 3'd4;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/wb_commit_stage_if.sv
// Bundle between MEM / dcache and the commit stage, plus the regfile write port
// and forwarding outputs the stage drives.
interface wb_commit_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_is_load;
  logic [2:0]        mem_load_op;
  logic [1:0]        mem_addr_lo;
  logic              dcache_rvalid;
  logic [DATA_W-1:0] dcache_rdata;
  logic              flush;

  logic              stall_req;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              mem_forwarding_we;
  logic [ADDR_W-1:0] mem_forwarding_waddr;
  logic [DATA_W-1:0] mem_forwarding_wdata;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    output mem_valid, mem_we, mem_waddr, mem_wdata, mem_is_load, mem_load_op,
           mem_addr_lo, dcache_rvalid, dcache_rdata, flush,
    input  stall_req, we, waddr, wdata, mem_forwarding_we, mem_forwarding_waddr,
           mem_forwarding_wdata, retired_cnt
  );

  modport slave (
    input  mem_valid, mem_we, mem_waddr, mem_wdata, mem_is_load, mem_load_op,
           mem_addr_lo, dcache_rvalid, dcache_rdata, flush,
    output stall_req, we, waddr, wdata, mem_forwarding_we, mem_forwarding_waddr,
           mem_forwarding_wdata, retired_cnt
  );
endinterface

// File: rtl/wb_commit_stage_load_align.sv
// Selects the addressed byte/halfword of a dcache word and sign/zero-extends it.
// Purely combinational so other load paths can share it.
module load_align
  import wb_commit_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        load_op,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] ext_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    // NOTE: default-assign every always_comb output first so no path infers a latch.
    ext_data = rdata;
    case (load_op)
      LOAD_LB:  ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_LH:  ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: ext_data = {{(DATA_W-16){1'b0}}, half_sel};
      default:  ext_data = rdata;
    endcase
  end
endmodule

// File: rtl/wb_commit_stage.sv
// Final pipeline stage: commits ALU results and (possibly delayed) load data to
// the register file, stalling MEM while a load response is outstanding.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  wb_commit_stage_if.slave bus
);
  state_e            state;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  retired_q;

  logic              pend_we;
  logic [ADDR_W-1:0] pend_waddr;
  logic [2:0]        pend_op;
  logic [1:0]        pend_lo;

  logic [2:0]        align_op;
  logic [1:0]        align_lo;
  logic [DATA_W-1:0] aligned;
  logic              accept;

  // A waiting load aligns with its latched op; otherwise use MEM's live fields.
  assign align_op = (state == ST_WAIT_LOAD) ? pend_op : bus.mem_load_op;
  assign align_lo = (state == ST_WAIT_LOAD) ? pend_lo : bus.mem_addr_lo;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata    (bus.dcache_rdata),
    .load_op  (align_op),
    .addr_lo  (align_lo),
    .ext_data (aligned)
  );

  assign accept = bus.mem_valid && (state == ST_IDLE) && !bus.flush;

  assign bus.stall_req            = (state == ST_WAIT_LOAD);
  assign bus.we                   = we_q;
  assign bus.waddr                = waddr_q;
  assign bus.wdata                = wdata_q;
  assign bus.mem_forwarding_we    = we_q;
  assign bus.mem_forwarding_waddr = waddr_q;
  assign bus.mem_forwarding_wdata = wdata_q;
  assign bus.retired_cnt          = retired_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= ZERO_WORD;
      retired_q  <= '0;
      pend_we    <= 1'b0;
      pend_waddr <= '0;
      pend_op    <= LOAD_LW;
      pend_lo    <= 2'b00;
    end else begin
      we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!bus.mem_is_load || bus.dcache_rvalid) begin
              we_q      <= bus.mem_we && (bus.mem_waddr != '0);
              waddr_q   <= bus.mem_waddr;
              wdata_q   <= bus.mem_is_load ? aligned : bus.mem_wdata;
              retired_q <= retired_q + 1'b1;
            end else begin
              pend_we    <= bus.mem_we;
              pend_waddr <= bus.mem_waddr;
              pend_op    <= bus.mem_load_op;
              pend_lo    <= bus.mem_addr_lo;
              state      <= ST_WAIT_LOAD;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (bus.dcache_rvalid) begin
            we_q      <= pend_we && (pend_waddr != '0);
            waddr_q   <= pend_waddr;
            wdata_q   <= aligned;
            retired_q <= retired_q + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
